mult_req_initiator: RTL and testbench
=====================================

Name: mult_req_initiator

Overview:
- Initiator for the arithmetic core's `req`/`ack`/`result_rdy` interface.
- Accepts operand commands on an upstream valid/ready port and generates argument parity (optionally corrupted for error injection).
- Drives `req` with the arguments until `ack`, then waits for `result_rdy`, checks result parity and returns a response record on a downstream valid/ready port.
- Sits between the stimulus/command source and the multiplier core; one transaction outstanding at a time.

Parameters:
- ARG_W, 16, operand width in bits (signed, two's complement).
- RES_W, 32, result width in bits; must equal 2*ARG_W.
- TIMEOUT, 64, max cycles from entering REQ to receiving `result_rdy`; range 2..65535.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  upstream command ready.
- cmd_a  input  ARG_W  operand A.
- cmd_b  input  ARG_W  operand B.
- cmd_err_a  input  1  invert generated parity of A (error injection).
- cmd_err_b  input  1  invert generated parity of B.
- req  output  1  request to core.
- arg_a  output  ARG_W  operand A to core.
- arg_a_parity  output  1  parity of arg_a.
- arg_b  output  ARG_W  operand B to core.
- arg_b_parity  output  1  parity of arg_b.
- ack  input  1  core accepted arguments (single-cycle pulse).
- result  input  RES_W  core result.
- result_parity  input  1  parity of result.
- result_rdy  input  1  result valid (single-cycle pulse).
- arg_parity_error  input  1  core detected argument parity error; qualified by result_rdy.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_result  output  RES_W  captured result; 0 on timeout.
- rsp_par_ok  output  1  1 = captured result_parity equals XOR of captured result.
- rsp_arg_err  output  1  captured arg_parity_error.
- rsp_timeout  output  1  transaction aborted by timeout.
- proto_err  output  1  sticky: ack or result_rdy seen outside the expected state; cleared only by reset.

Behaviour:
- Parity rule: parity = XOR-reduce of the data bits, i.e. data plus parity has an even number of ones. Outgoing parity is XORed with cmd_err_x.
- Reset values: cmd_ready=1, req=0, arg_a=0, arg_b=0, both parities=0, rsp_valid=0, rsp_result=0, rsp_par_ok=0, rsp_arg_err=0, rsp_timeout=0, proto_err=0.
- Reset mid-transaction drops to IDLE immediately; the in-flight transaction is lost with no response.
- FSM states: IDLE, REQ, WAIT_RES, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register operands and parities, set req=1, clear timer, go to REQ.
  - arg_* are stable from the first req cycle.
- REQ:
  - req=1; arg_* held constant.
  - On ack: req=0 next cycle, go to WAIT_RES.
  - If ack and result_rdy arrive in the same cycle: capture the result and go directly to RESP.
- WAIT_RES:
  - req=0; arg_* hold their last values.
  - On result_rdy: capture result, compute rsp_par_ok, capture arg_parity_error, go to RESP.
- Timer:
  - Counts every cycle in REQ and WAIT_RES.
  - When it reaches TIMEOUT-1 without result_rdy: go to RESP with rsp_timeout=1, rsp_result=0, rsp_par_ok=0, rsp_arg_err=0, and req=0.
  - result_rdy in the final cycle wins over timeout.
- RESP:
  - rsp_valid=1; response fields held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE.
  - cmd_ready=0 in REQ, WAIT_RES and RESP.
- proto_err set when:
  - ack arrives in IDLE, WAIT_RES or RESP;
  - result_rdy arrives in IDLE, REQ (without ack) or RESP.
  - Stray pulses are otherwise ignored and change no other state.
- Latency: command accepted at cycle 0 gives req high in cycle 1; the response is valid 1 cycle after the capturing result_rdy edge.
- Throughput: at most 1 transaction per (core latency + 3) cycles.

Test Plan:
- Basic: a=3, b=5, no injection:
  - arg_a_parity=0, arg_b_parity=0, req high until ack;
  - core returns 15 with parity 0 -> rsp_result=32'h0000000F, rsp_par_ok=1, rsp_arg_err=0, rsp_timeout=0.
- Signed: a=16'hFFFE (-2), b=3 -> arg_a_parity=1, arg_b_parity=0; result 32'hFFFFFFFA with parity 0 -> rsp_par_ok=1.
- Injection: a=1, b=7, cmd_err_a=1:
  - arg_a_parity=0 (correct value is 1);
  - core returns arg_parity_error=1 -> rsp_arg_err=1.
  - Corrupt result_parity in a separate case -> rsp_par_ok=0.
- Timeout: TIMEOUT=8, core never acks -> req drops and rsp_valid rises, with rsp_timeout=1 and rsp_result=0, 8 cycles after req rose. Repeat with ack but no result_rdy -> same response.
- Corners:
  - ack and result_rdy in the same cycle -> single response, no proto_err.
  - Stray result_rdy in IDLE -> proto_err=1, no rsp_valid.
  - rsp_ready held low 5 cycles -> fields stable, cmd_ready stays 0.
- Reset mid-op: assert rst_n=0 during WAIT_RES -> all outputs at reset values immediately. After release, new command a=2, b=2 -> rsp_result=4.

Source files
------------

// File: rtl/mult_req_initiator.sv
// rtl/mult_req_initiator.sv - parity-protected req/ack initiator for the multiplier core
module mult_req_initiator #(
    parameter int ARG_W   = 16,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ARG_W-1:0] cmd_a,
    input  logic [ARG_W-1:0] cmd_b,
    input  logic             cmd_err_a,
    input  logic             cmd_err_b,
    output logic             req,
    output logic [ARG_W-1:0] arg_a,
    output logic             arg_a_parity,
    output logic [ARG_W-1:0] arg_b,
    output logic             arg_b_parity,
    input  logic             ack,
    input  logic [RES_W-1:0] result,
    input  logic             result_parity,
    input  logic             result_rdy,
    input  logic             arg_parity_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_par_ok,
    output logic             rsp_arg_err,
    output logic             rsp_timeout,
    output logic             proto_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RES, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic        accept;
    logic        capture;
    logic        time_out;
    logic        last_cycle;
    logic        proto_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A result that lands on the final timer cycle is taken in preference to the timeout.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        time_out   = 1'b0;
        last_cycle = (timer == 16'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack && result_rdy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (last_cycle) begin
                    time_out  = 1'b1;
                    state_nxt = RESP;
                end else if (ack) begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (result_rdy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (last_cycle) begin
                    time_out  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        proto_hit = 1'b0;
        if (ack && (state == IDLE || state == WAIT_RES || state == RESP)) begin
            proto_hit = 1'b1;
        end
        if (result_rdy && (state == IDLE || state == RESP || (state == REQ && !ack))) begin
            proto_hit = 1'b1;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign req       = (state == REQ);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            arg_a        <= '0;
            arg_b        <= '0;
            arg_a_parity <= 1'b0;
            arg_b_parity <= 1'b0;
            rsp_result   <= '0;
            rsp_par_ok   <= 1'b0;
            rsp_arg_err  <= 1'b0;
            rsp_timeout  <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            proto_err <= proto_err | proto_hit;
            if (accept) begin
                timer        <= '0;
                arg_a        <= cmd_a;
                arg_b        <= cmd_b;
                arg_a_parity <= (^cmd_a) ^ cmd_err_a;
                arg_b_parity <= (^cmd_b) ^ cmd_err_b;
            end else if (state == REQ || state == WAIT_RES) begin
                timer <= timer + 16'd1;
            end
            if (capture) begin
                rsp_result  <= result;
                rsp_par_ok  <= ~((^result) ^ result_parity);
                rsp_arg_err <= arg_parity_error;
                rsp_timeout <= 1'b0;
            end else if (time_out) begin
                rsp_result  <= '0;
                rsp_par_ok  <= 1'b0;
                rsp_arg_err <= 1'b0;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_req_initiator.sv
// tb/tb_mult_req_initiator.sv - self-checking bench for mult_req_initiator
module tb_mult_req_initiator;

    localparam int ARG_W = 16;
    localparam int RES_W = 32;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ARG_W-1:0] cmd_a;
    logic [ARG_W-1:0] cmd_b;
    logic             cmd_err_a;
    logic             cmd_err_b;
    logic             req;
    logic [ARG_W-1:0] arg_a;
    logic             arg_a_parity;
    logic [ARG_W-1:0] arg_b;
    logic             arg_b_parity;
    logic             ack;
    logic [RES_W-1:0] result;
    logic             result_parity;
    logic             result_rdy;
    logic             arg_parity_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_par_ok;
    logic             rsp_arg_err;
    logic             rsp_timeout;
    logic             proto_err;

    always #5 clk = ~clk;

    mult_req_initiator #(.ARG_W(ARG_W), .RES_W(RES_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_err_a(cmd_err_a), .cmd_err_b(cmd_err_b),
        .req(req), .arg_a(arg_a), .arg_a_parity(arg_a_parity),
        .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .ack(ack), .result(result), .result_parity(result_parity),
        .result_rdy(result_rdy), .arg_parity_error(arg_parity_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_par_ok(rsp_par_ok), .rsp_arg_err(rsp_arg_err),
        .rsp_timeout(rsp_timeout), .proto_err(proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ea;
        logic        eb;
        int          d;
        int          r;
        logic        corrupt;
        int          hold;
        logic        epa;
        logic        epb;
        logic [31:0] eres;
        logic        epok;
        logic        earg;
        logic        eto;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] product(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    // Reference: decide outcome from the ack/result offsets against the timeout window.
    function automatic vec_t make_random();
        vec_t v;
        logic res_ok;
        v.a       = 16'($urandom);
        v.b       = 16'($urandom);
        v.ea      = ($urandom_range(0, 3) == 0);
        v.eb      = ($urandom_range(0, 3) == 0);
        v.d       = $urandom_range(0, 9);
        v.r       = $urandom_range(0, 4);
        v.corrupt = ($urandom_range(0, 3) == 0);
        v.hold    = $urandom_range(0, 3);
        v.epa     = (^v.a) ^ v.ea;
        v.epb     = (^v.b) ^ v.eb;
        res_ok    = (v.d <= TO - 1) && (v.d + v.r <= TO - 1);
        v.eto     = !res_ok;
        v.eres    = res_ok ? product(v.a, v.b) : 32'd0;
        v.epok    = res_ok && !v.corrupt;
        v.earg    = res_ok && (v.ea || v.eb);
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        bit          ack_ok;
        bit          res_ok;
        int          res_off;
        int          end_off;
        logic [31:0] prod;
        ack_ok  = (v.d <= TO - 1);
        res_off = v.d + v.r;
        res_ok  = ack_ok && (res_off <= TO - 1);
        end_off = res_ok ? res_off : TO - 1;
        prod    = product(v.a, v.b);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_err_a = v.ea;
        cmd_err_b = v.eb;
        chk({tag, " cmd_ready idle"}, cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        for (int k = 0; k <= end_off; k++) begin
            chk({tag, " req"}, req, (k <= v.d));
            chk({tag, " cmd_ready busy"}, cmd_ready, 1'b0);
            chk({tag, " rsp_valid early"}, rsp_valid, 1'b0);
            if (k == 0 || k == end_off) begin
                chk({tag, " arg_a"}, arg_a, v.a);
                chk({tag, " arg_b"}, arg_b, v.b);
                chk({tag, " arg_a_parity"}, arg_a_parity, v.epa);
                chk({tag, " arg_b_parity"}, arg_b_parity, v.epb);
            end
            ack        = ack_ok && (k == v.d);
            result_rdy = res_ok && (k == res_off);
            if (result_rdy) begin
                result           = prod;
                result_parity    = (^prod) ^ v.corrupt;
                arg_parity_error = v.ea | v.eb;
            end else begin
                result           = $urandom;
                result_parity    = 1'($urandom);
                arg_parity_error = 1'($urandom);
            end
            @(negedge clk);
        end
        ack        = 1'b0;
        result_rdy = 1'b0;
        chk({tag, " req after"}, req, 1'b0);
        for (int h = 0; h <= v.hold; h++) begin
            if (h == v.hold) rsp_ready = 1'b1;
            chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
            chk({tag, " cmd_ready resp"}, cmd_ready, 1'b0);
            chk({tag, " rsp_result"}, rsp_result, v.eres);
            chk({tag, " rsp_par_ok"}, rsp_par_ok, v.epok);
            chk({tag, " rsp_arg_err"}, rsp_arg_err, v.earg);
            chk({tag, " rsp_timeout"}, rsp_timeout, v.eto);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid done"}, rsp_valid, 1'b0);
        chk({tag, " cmd_ready done"}, cmd_ready, 1'b1);
        chk({tag, " proto_err"}, proto_err, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, " req"}, req, 1'b0);
        chk({tag, " arg_a"}, arg_a, 16'd0);
        chk({tag, " arg_b"}, arg_b, 16'd0);
        chk({tag, " arg_a_parity"}, arg_a_parity, 1'b0);
        chk({tag, " arg_b_parity"}, arg_b_parity, 1'b0);
        chk({tag, " rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, " rsp_result"}, rsp_result, 32'd0);
        chk({tag, " rsp_par_ok"}, rsp_par_ok, 1'b0);
        chk({tag, " rsp_arg_err"}, rsp_arg_err, 1'b0);
        chk({tag, " rsp_timeout"}, rsp_timeout, 1'b0);
        chk({tag, " proto_err"}, proto_err, 1'b0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_err_a = 1'b0; cmd_err_b = 1'b0; ack = 1'b0; result = '0;
        result_parity = 1'b0; result_rdy = 1'b0; arg_parity_error = 1'b0;
        rsp_ready = 1'b0;

        //         a         b         ea    eb    d   r   cor   hold epa   epb   eres          epok  earg  eto
        tbl[0] = '{16'd3,    16'd5,    1'b0, 1'b0, 2,  3,  1'b0, 0,   1'b0, 1'b0, 32'h0000000F, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFE, 16'd3,    1'b0, 1'b0, 0,  2,  1'b0, 1,   1'b1, 1'b0, 32'hFFFFFFFA, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'd1,    16'd7,    1'b1, 1'b0, 1,  1,  1'b0, 0,   1'b0, 1'b1, 32'h00000007, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{16'd6,    16'd9,    1'b0, 1'b0, 1,  2,  1'b1, 0,   1'b0, 1'b0, 32'h00000036, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'd5,    16'd5,    1'b0, 1'b0, 99, 0,  1'b0, 0,   1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'd5,    16'd6,    1'b0, 1'b0, 2,  99, 1'b0, 0,   1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{16'd4,    16'd4,    1'b0, 1'b0, 1,  0,  1'b0, 0,   1'b1, 1'b1, 32'h00000010, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{16'd10,   16'hFFFF, 1'b0, 1'b0, 1,  1,  1'b0, 5,   1'b0, 1'b0, 32'hFFFFFFF6, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{16'd2,    16'd3,    1'b0, 1'b0, 3,  4,  1'b0, 0,   1'b1, 1'b0, 32'h00000006, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{16'd2,    16'd3,    1'b0, 1'b0, 3,  5,  1'b0, 0,   1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

        @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v = make_random();
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Reset while waiting for the result, then a clean transaction.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h0002;
        cmd_err_a = 1'b0; cmd_err_b = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("midop in wait_res", req, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midop reset");
        @(negedge clk);
        rst_n = 1'b1;
        v = '{16'd2, 16'd2, 1'b0, 1'b0, 1, 1, 1'b0, 0, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0};
        run_txn(v, "after_reset");

        // Stray result_rdy while idle.
        @(negedge clk);
        result_rdy = 1'b1;
        @(negedge clk);
        result_rdy = 1'b0;
        chk("stray proto_err", proto_err, 1'b1);
        chk("stray rsp_valid", rsp_valid, 1'b0);
        chk("stray cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("stray proto_err sticky", proto_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
